// File: rtl/dcache_if.sv
// CPU-side and memory-side signal bundle of the data cache.
// slave  : the cache controller itself.
// master : the surrounding environment (CPU datapath plus Data_Memory).
interface dcache_if;
  logic        read;
  logic        write;
  logic [7:0]  address;
  logic [7:0]  writedata;
  logic [7:0]  readdata;
  logic        busywait;
  logic        mem_read;
  logic        mem_write;
  logic [5:0]  mem_address;
  logic [31:0] mem_writedata;
  logic [31:0] mem_readdata;
  logic        mem_busywait;

  modport slave (
    input  read, write, address, writedata, mem_readdata, mem_busywait,
    output readdata, busywait, mem_read, mem_write, mem_address, mem_writedata
  );

  modport master (
    output read, write, address, writedata, mem_readdata, mem_busywait,
    input  readdata, busywait, mem_read, mem_write, mem_address, mem_writedata
  );
endinterface

// File: rtl/dcache_controller.sv
// Direct-mapped, write-back, write-allocate byte data cache.
// Hits complete with zero stall; misses go through an optional victim
// write-back, a block fetch and a line update before the access re-hits.
module dcache_controller #(
  parameter int NUM_BLOCKS = 8,
  parameter int MEM_ADDR_W = 6
) (
  input  logic     clock,
  input  logic     reset,
  dcache_if.slave  bus
);
  localparam int IDX_W = $clog2(NUM_BLOCKS);
  localparam int TAG_W = MEM_ADDR_W - IDX_W;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WRITEBACK = 2'd1,
    FETCH     = 2'd2,
    UPDATE    = 2'd3
  } state_t;

  state_t                 state;
  logic [NUM_BLOCKS-1:0]  valid;
  logic [NUM_BLOCKS-1:0]  dirty;
  logic [TAG_W-1:0]       tags [NUM_BLOCKS];
  logic [31:0]            data [NUM_BLOCKS];
  logic [31:0]            fill_data;

  logic [IDX_W-1:0]       idx;
  logic [TAG_W-1:0]       tag_in;
  logic [1:0]             offset;
  logic                   req;
  logic                   hit;
  logic [7:0]             sel_byte;

  assign idx    = bus.address[IDX_W+1:2];
  assign tag_in = bus.address[7:IDX_W+2];
  assign offset = bus.address[1:0];
  // read and write together is treated as no request at all
  assign req    = bus.read ^ bus.write;
  assign hit    = valid[idx] && (tags[idx] == tag_in);

  // Load byte selection and the CPU stall, both combinational so hits never stall.
  always_comb begin
    sel_byte = 8'h00;
    case (offset)
      2'd0:    sel_byte = data[idx][7:0];
      2'd1:    sel_byte = data[idx][15:8];
      2'd2:    sel_byte = data[idx][23:16];
      2'd3:    sel_byte = data[idx][31:24];
      default: sel_byte = 8'h00;
    endcase
    if (reset && bus.read && !bus.write && hit) begin
      bus.readdata = sel_byte;
    end else begin
      bus.readdata = 8'h00;
    end
    bus.busywait = reset && req && !((state == IDLE) && hit);
  end

  // Miss-handling FSM, memory-port outputs and line storage updates.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state             <= IDLE;
      valid             <= '0;
      dirty             <= '0;
      fill_data         <= 32'h0000_0000;
      bus.mem_read      <= 1'b0;
      bus.mem_write     <= 1'b0;
      bus.mem_address   <= '0;
      bus.mem_writedata <= 32'h0000_0000;
      for (int i = 0; i < NUM_BLOCKS; i++) begin
        tags[i] <= '0;
        data[i] <= 32'h0000_0000;
      end
    end else begin
      case (state)
        IDLE: begin
          if (req && hit) begin
            if (bus.write) begin
              data[idx][{offset, 3'b000} +: 8] <= bus.writedata;
              dirty[idx]                       <= 1'b1;
            end
          end else if (req) begin
            if (valid[idx] && dirty[idx]) begin
              // victim must reach memory before its slot is refilled
              state             <= WRITEBACK;
              bus.mem_write     <= 1'b1;
              bus.mem_address   <= {tags[idx], idx};
              bus.mem_writedata <= data[idx];
            end else begin
              state           <= FETCH;
              bus.mem_read    <= 1'b1;
              bus.mem_address <= {tag_in, idx};
            end
          end
        end
        WRITEBACK: begin
          if (!bus.mem_busywait) begin
            state           <= FETCH;
            bus.mem_write   <= 1'b0;
            bus.mem_read    <= 1'b1;
            bus.mem_address <= {tag_in, idx};
          end
        end
        FETCH: begin
          if (!bus.mem_busywait) begin
            state        <= UPDATE;
            bus.mem_read <= 1'b0;
            fill_data    <= bus.mem_readdata;
          end
        end
        UPDATE: begin
          data[idx]  <= fill_data;
          tags[idx]  <= tag_in;
          valid[idx] <= 1'b1;
          dirty[idx] <= 1'b0;
          state      <= IDLE;
        end
        default: begin
          state         <= IDLE;
          bus.mem_read  <= 1'b0;
          bus.mem_write <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_dcache_controller.sv
// Bench for dcache_controller: a latency-programmable Data_Memory model and
// an architectural reference (flat byte memory plus line presence table).
module tb_dcache_controller;
  logic clock = 1'b0;
  logic reset = 1'b0;
  dcache_if bus();

  dcache_controller dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;

  // Data_Memory model: busy for mem_lat cycles of a request, then completes
  logic [31:0] mem [64];
  int          mem_lat = 0;
  int          mcnt = 0;
  assign bus.mem_busywait = (bus.mem_read || bus.mem_write) && (mcnt != mem_lat);
  assign bus.mem_readdata = mem[bus.mem_address];

  // Memory request progress and write commit.
  always @(posedge clock) begin
    if (bus.mem_read || bus.mem_write) begin
      if (mcnt == mem_lat) begin
        if (bus.mem_write) mem[bus.mem_address] <= bus.mem_writedata;
        mcnt <= 0;
      end else begin
        mcnt <= mcnt + 1;
      end
    end else begin
      mcnt <= 0;
    end
  end

  // Reference: what every byte address must read as, and which lines are present
  logic [7:0] flat [256];
  bit         m_valid [8];
  bit         m_dirty [8];
  logic [2:0] m_tag [8];

  bit          expect_wb = 1'b0;
  logic [5:0]  exp_wb_addr = 6'd0;
  logic [31:0] exp_wb_data = 32'h0;
  logic [5:0]  exp_fetch_addr = 6'd0;
  bit          saw_wb = 1'b0;
  logic [5:0]  last_wb_addr = 6'd0;
  logic [31:0] last_wb_data = 32'h0;
  logic [5:0]  last_fetch_addr = 6'd0;
  int          last_stall = 0;
  logic [7:0]  last_read = 8'h00;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Per-cycle compare of the memory port and reset outputs.
  always @(negedge clock) begin
    if (!reset) begin
      check("rst_busywait", {31'd0, bus.busywait}, 32'd0);
      check("rst_mem_read", {31'd0, bus.mem_read}, 32'd0);
      check("rst_mem_write", {31'd0, bus.mem_write}, 32'd0);
      check("rst_readdata", {24'd0, bus.readdata}, 32'd0);
    end else begin
      check("rd_wr_exclusive", {31'd0, bus.mem_read & bus.mem_write}, 32'd0);
      check("unexpected_wb", {31'd0, bus.mem_write & ~expect_wb}, 32'd0);
      if (bus.mem_write) begin
        saw_wb       = 1'b1;
        last_wb_addr = bus.mem_address;
        last_wb_data = bus.mem_writedata;
        check("wb_addr", {26'd0, bus.mem_address}, {26'd0, exp_wb_addr});
        check("wb_data", bus.mem_writedata, exp_wb_data);
      end
      if (bus.mem_read) begin
        last_fetch_addr = bus.mem_address;
        check("fetch_addr", {26'd0, bus.mem_address}, {26'd0, exp_fetch_addr});
      end
    end
  end

  task automatic sync_model();
    for (int b = 0; b < 64; b++) begin
      for (int k = 0; k < 4; k++) flat[b*4+k] = mem[b][k*8 +: 8];
    end
    for (int i = 0; i < 8; i++) begin
      m_valid[i] = 1'b0;
      m_dirty[i] = 1'b0;
      m_tag[i]   = 3'd0;
    end
  endtask

  task automatic do_reset();
    @(posedge clock); #1;
    reset = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    reset = 1'b1;
    sync_model();
  endtask

  // One CPU access: predicted stall, load data and model update.
  task automatic access(input bit rd, input bit wr, input logic [7:0] a,
                        input logic [7:0] d, input int lat);
    logic [2:0] ix;
    logic [2:0] tg;
    logic [7:0] vb;
    bit         both;
    bit         is_hit;
    bit         dv;
    int         stall;
    int         exp_stall;
    ix     = a[4:2];
    tg     = a[7:5];
    both   = rd && wr;
    is_hit = m_valid[ix] && (m_tag[ix] == tg);
    dv     = !both && !is_hit && m_valid[ix] && m_dirty[ix];
    vb     = {m_tag[ix], ix, 2'b00};
    exp_wb_addr    = {m_tag[ix], ix};
    exp_wb_data    = {flat[vb | 8'd3], flat[vb | 8'd2], flat[vb | 8'd1], flat[vb]};
    exp_fetch_addr = {tg, ix};
    expect_wb      = dv;
    saw_wb         = 1'b0;
    mem_lat        = lat;
    bus.read = rd; bus.write = wr; bus.address = a; bus.writedata = d;
    stall = 0;
    @(negedge clock);
    if (both) begin
      check("both_mem_read", {31'd0, bus.mem_read}, 32'd0);
      check("both_mem_write", {31'd0, bus.mem_write}, 32'd0);
    end
    while (bus.busywait && stall < 60) begin
      stall++;
      @(negedge clock);
    end
    if (both || is_hit)      exp_stall = 0;
    else if (dv)             exp_stall = 2 * lat + 4;
    else                     exp_stall = lat + 3;
    check("stall", stall, exp_stall);
    last_stall = stall;
    last_read  = bus.readdata;
    if (rd && !wr) check("readdata", {24'd0, bus.readdata}, {24'd0, flat[a]});
    @(posedge clock); #1;
    bus.read = 1'b0; bus.write = 1'b0;
    expect_wb = 1'b0;
    if (!both) begin
      if (!is_hit) begin
        m_tag[ix]   = tg;
        m_valid[ix] = 1'b1;
        m_dirty[ix] = 1'b0;
      end
      if (wr) begin
        flat[a]     = d;
        m_dirty[ix] = 1'b1;
      end
    end
  endtask

  initial begin
    bus.read = 1'b0; bus.write = 1'b0; bus.address = 8'h00; bus.writedata = 8'h00;
    for (int b = 0; b < 64; b++) mem[b] = $urandom;
    mem[0] = 32'h4433_2211;
    sync_model();
    repeat (2) @(posedge clock);
    #1;
    reset = 1'b1;

    // reset asserted while a fetch is in flight
    @(posedge clock); #1;
    exp_fetch_addr = 6'd0;
    mem_lat = 6;
    bus.read = 1'b1; bus.address = 8'h00;
    repeat (3) @(posedge clock);
    #2;
    reset = 1'b0;
    #1;
    check("midfetch_mem_read", {31'd0, bus.mem_read}, 32'd0);
    check("midfetch_busywait", {31'd0, bus.busywait}, 32'd0);
    bus.read = 1'b0;
    repeat (2) @(posedge clock);
    @(negedge clock);
    reset = 1'b1;
    sync_model();
    @(posedge clock); #1;
    access(1'b1, 1'b0, 8'h00, 8'h00, 1);
    check("post_reset_miss_stall", last_stall, 32'd4);
    do_reset();

    // fill, hit, write hit, dirty eviction
    access(1'b1, 1'b0, 8'h02, 8'h00, 2);
    check("lit_rd02", {24'd0, last_read}, 32'h33);
    check("lit_rd02_stall", last_stall, 32'd5);
    access(1'b1, 1'b0, 8'h02, 8'h00, 2);
    check("lit_rd02_hit_stall", last_stall, 32'd0);
    access(1'b0, 1'b1, 8'h01, 8'hAB, 2);
    check("lit_wr01_stall", last_stall, 32'd0);
    access(1'b1, 1'b0, 8'h01, 8'h00, 2);
    check("lit_rd01", {24'd0, last_read}, 32'hAB);
    check("lit_no_wb_yet", {31'd0, saw_wb}, 32'd0);
    access(1'b0, 1'b1, 8'h21, 8'hAB, 1);
    check("lit_wb_addr", {26'd0, last_wb_addr}, 32'd0);
    check("lit_wb_data", last_wb_data, 32'h4433_AB11);
    check("lit_fetch_addr", {26'd0, last_fetch_addr}, 32'd8);
    check("lit_wb_stall", last_stall, 32'd6);
    access(1'b1, 1'b0, 8'h21, 8'h00, 1);
    check("lit_rd21", {24'd0, last_read}, 32'hAB);

    // simultaneous read and write is a no-op
    access(1'b1, 1'b1, 8'h21, 8'h55, 1);
    access(1'b1, 1'b0, 8'h21, 8'h00, 1);
    check("lit_rd21_after_both", {24'd0, last_read}, 32'hAB);

    // conflicting clean lines: every access misses, never writes back
    for (int i = 0; i < 6; i++) begin
      access(1'b1, 1'b0, (i % 2 == 0) ? 8'h04 : 8'h24, 8'h00, 0);
      check("conflict_miss", {31'd0, last_stall != 0}, 32'd1);
      check("conflict_no_wb", {31'd0, saw_wb}, 32'd0);
    end

    // random traffic over a few tags so hits, misses and evictions mix
    for (int i = 0; i < 400; i++) begin
      int op;
      logic [7:0] a;
      op = $urandom_range(0, 9);
      a  = 8'($urandom) & 8'h7F;
      access(op < 5 || op == 9, op >= 5, a, 8'($urandom), $urandom_range(0, 3));
    end

    // dirty lines are discarded on reset
    do_reset();
    for (int i = 0; i < 60; i++) begin
      int op;
      op = $urandom_range(0, 9);
      access(op < 5 || op == 9, op >= 5, 8'($urandom) & 8'h7F, 8'($urandom), $urandom_range(0, 3));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
